// File: rtl/screen_flow_pkg.sv
// Shared types and widths for the screen sequencer.
package screen_flow_pkg;

    localparam int CNT_W   = 27;
    localparam int LIVES_W = 4;
    localparam int LEVEL_W = 3;

    typedef enum logic [2:0] {
        OPEN  = 3'd0,
        GAME  = 3'd1,
        VICT  = 3'd2,
        FAIL  = 3'd3,
        PAUSE = 3'd4
    } screen_state_t;

    // {is_open, is_game, is_vict, is_fail}; PAUSE keeps the playfield drawn.
    function automatic logic [3:0] state_flags(input screen_state_t s);
        case (s)
            OPEN:        state_flags = 4'b1000;
            GAME, PAUSE: state_flags = 4'b0100;
            VICT:        state_flags = 4'b0010;
            FAIL:        state_flags = 4'b0001;
            default:     state_flags = 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/screen_flow_ctrl_key_edge_sync.sv
// Two-flop synchronizer for a raw key level followed by a registered
// rising-edge pulse (pulse appears 3 cycles after the raw rise).
module key_edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic key_raw,
    output logic key_edge
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            prev_p2  <= 1'b0;
            key_edge <= 1'b0;
        end else begin
            sync_p0  <= key_raw;
            sync_p1  <= sync_p0;
            prev_p2  <= sync_p1;
            key_edge <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/screen_flow_ctrl.sv
// Screen sequencer: phase flags, level, lives, ring blink and end-screen hold.
// Define SCREEN_PAUSE_EN to add the pause_key input and the PAUSE state.
module screen_flow_ctrl
    import screen_flow_pkg::*;
#(
    parameter int BLINK_PERIOD = 50000000,
    parameter int BLINK_HIGH   = 25000000,
    parameter int NUM_LEVELS   = 5,
    parameter int START_LIVES  = 10,
    parameter int END_HOLD     = 100000000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                start_key,
`ifdef SCREEN_PAUSE_EN
    input  logic                pause_key,
`endif
    input  logic                frame_start,
    input  logic                carrot_hit,
    input  logic                wave_done,
    output logic                is_open,
    output logic                is_game,
    output logic                is_vict,
    output logic                is_fail,
    output logic [LEVEL_W-1:0]  level_index,
    output logic [LIVES_W-1:0]  lives,
    output logic                blink_phase,
    output logic                hold_busy
);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0]   BLINK_HI   = CNT_W'(BLINK_HIGH);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(END_HOLD - 1);

    screen_state_t        state;
    screen_state_t        pend_state;
    logic                 pend_valid;
    logic [CNT_W-1:0]     blink_cnt;
    logic [CNT_W-1:0]     hold_cnt;

    logic                 start_edge;
    logic                 req_valid;
    screen_state_t        req_state;
    logic                 life_dec;
    logic                 level_inc;

    key_edge_sync u_start_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .key_raw  (start_key),
        .key_edge (start_edge)
    );

`ifdef SCREEN_PAUSE_EN
    logic pause_edge;

    key_edge_sync u_pause_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .key_raw  (pause_key),
        .key_edge (pause_edge)
    );
`endif

    // Event decode; nothing new is accepted while a transition is pending.
    always_comb begin
        req_valid = 1'b0;
        req_state = state;
        life_dec  = 1'b0;
        level_inc = 1'b0;
        if (!pend_valid) begin
            case (state)
                OPEN: begin
                    if (start_edge) begin
                        req_valid = 1'b1;
                        req_state = GAME;
                    end
                end
                GAME: begin
`ifdef SCREEN_PAUSE_EN
                    if (pause_edge) begin
                        req_valid = 1'b1;
                        req_state = PAUSE;
                    end
`endif
                    if (wave_done) begin
                        if (level_index == LAST_LEVEL) begin
                            req_valid = 1'b1;
                            req_state = VICT;
                        end else begin
                            level_inc = 1'b1;
                        end
                    end
                    // Checked after the wave so a fatal hit overrides victory.
                    if (carrot_hit && lives != '0) begin
                        life_dec = 1'b1;
                        if (lives == LIVES_W'(1)) begin
                            req_valid = 1'b1;
                            req_state = FAIL;
                        end
                    end
                end
`ifdef SCREEN_PAUSE_EN
                PAUSE: begin
                    if (pause_edge) begin
                        req_valid = 1'b1;
                        req_state = GAME;
                    end
                end
`endif
                VICT, FAIL: begin
                    if (start_edge && !hold_busy) begin
                        req_valid = 1'b1;
                        req_state = OPEN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= OPEN;
            pend_state  <= OPEN;
            pend_valid  <= 1'b0;
            is_open     <= 1'b1;
            is_game     <= 1'b0;
            is_vict     <= 1'b0;
            is_fail     <= 1'b0;
            level_index <= '0;
            lives       <= LIVES_INIT;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            hold_cnt    <= '0;
            hold_busy   <= 1'b0;
        end else if (frame_start && pend_valid) begin
            state      <= pend_state;
            pend_valid <= 1'b0;
            {is_open, is_game, is_vict, is_fail} <= state_flags(pend_state);
            case (pend_state)
                GAME: begin
                    // Resuming from PAUSE keeps the game in progress.
                    if (state == OPEN) begin
                        lives       <= LIVES_INIT;
                        level_index <= '0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b1;
                    end
                end
                VICT, FAIL: begin
                    hold_cnt  <= '0;
                    hold_busy <= 1'b1;
                end
                default: ;
            endcase
        end else begin
            if (req_valid) begin
                pend_valid <= 1'b1;
                pend_state <= req_state;
            end
            if (life_dec)
                lives <= lives - LIVES_W'(1);
            if (level_inc)
                level_index <= level_index + LEVEL_W'(1);
            if (state == GAME) begin
                blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + CNT_W'(1);
                blink_phase <= (blink_cnt < BLINK_HI);
            end
            if ((state == VICT || state == FAIL) && hold_busy) begin
                if (hold_cnt == HOLD_LAST)
                    hold_busy <= 1'b0;
                else
                    hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule
